// File: rtl/result_packer_pkg.sv
// Shared definitions for the result packer.
// This package holds the default geometry, the derived vector length (L) and
// vectors-per-word (N), the FSM state encoding, and the tag field layout.
// The tag fields are used only when RESULT_PACKER_TAG_EN is defined.
package result_packer_pkg;

  localparam int DATA_WIDTH_MAC_DEF      = 4;
  localparam int COLUMNS_DEF             = 3;
  localparam int DATA_WIDTH_FIFO_OUT_DEF = 64;
  localparam int CNT_WIDTH_DEF           = 16;

  // Whole vectors that fit in one output word (floor).
  function automatic int calc_n(input int width_out, input int vec_len);
    return width_out / vec_len;
  endfunction

  localparam int L_DEF = DATA_WIDTH_MAC_DEF * COLUMNS_DEF;
  localparam int N_DEF = calc_n(DATA_WIDTH_FIFO_OUT_DEF, L_DEF);

  // Tag layout, counted down from the word MSB: parity bit, then a 3-bit vector count.
  localparam int TAG_WIDTH           = 4;
  localparam int TAG_CNT_WIDTH       = 3;
  localparam int TAG_PARITY_FROM_TOP = 1;
  localparam int TAG_CNT_FROM_TOP    = 2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/result_packer_if.sv
// Result bus from the MXU and write port of the output FIFO.
// The master modport is the environment: the MXU result path plus the FIFO.
// The slave modport is the packer.
interface result_packer_if #(
  parameter int L = 12,
  parameter int W = 64
);
  logic         res_valid;
  logic [L-1:0] res_data;
  logic         res_ready;
  logic         outfifo_is_full;
  logic [W-1:0] outfifo_din;
  logic         outfifo_write;

  modport master (
    output res_valid, res_data, outfifo_is_full,
    input  res_ready, outfifo_din, outfifo_write
  );

  modport slave (
    input  res_valid, res_data, outfifo_is_full,
    output res_ready, outfifo_din, outfifo_write
  );
endinterface

// File: rtl/result_packer_slot_mux.sv
// Slot steering for the pack register.
// The first output writes the incoming vector into slot fill_i when wr_en_i is set.
// The second output is the word to be held: slots at or above valid_cnt_i are
// forced to zero, so a flushed partial word carries no stale data.
module result_packer_slot_mux #(
  parameter int L  = 12,
  parameter int N  = 5,
  parameter int FW = 3
) (
  input  logic [N*L-1:0] pack_i,
  input  logic [FW-1:0]  fill_i,
  input  logic [L-1:0]   vec_i,
  input  logic           wr_en_i,
  input  logic [FW-1:0]  valid_cnt_i,
  output logic [N*L-1:0] pack_o,
  output logic [N*L-1:0] word_o
);

  // Write the incoming vector into its slot.
  always_comb begin
    pack_o = pack_i;
    for (int i = 0; i < N; i++) begin
      if (wr_en_i && (fill_i == FW'(i))) pack_o[i*L +: L] = vec_i;
    end
  end

  // Keep only the valid slots; the tail stays zero.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < N; i++) begin
      if (FW'(i) < valid_cnt_i) word_o[i*L +: L] = pack_o[i*L +: L];
    end
  end

endmodule

// File: rtl/result_packer.sv
// Packs MXU result vectors LSB-first into output FIFO words.
// A flush request emits any pending partial word, zero-padded.
// Optional macro: RESULT_PACKER_TAG_EN. When it is defined, the top 4 bits of
// each word carry the parity bit and the valid-vector count.
//
// state   | meaning
// S_RUN   | accept vectors; full words go to the holding register
// S_FLUSH | stop accepting; move the partial word to holding once it is free
// S_DRAIN | wait for the held word to be written, then pulse flush_done
module result_packer
  import result_packer_pkg::*;
#(
  parameter int DATA_WIDTH_MAC      = DATA_WIDTH_MAC_DEF,
  parameter int COLUMNS             = COLUMNS_DEF,
  parameter int DATA_WIDTH_FIFO_OUT = DATA_WIDTH_FIFO_OUT_DEF,
  parameter int CNT_WIDTH           = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] words_written,
  output logic                 busy,
  result_packer_if.slave       bus
);

  localparam int L  = DATA_WIDTH_MAC * COLUMNS;
  localparam int N  = calc_n(DATA_WIDTH_FIFO_OUT, L);
  localparam int PL = N * L;
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

  if (N < 1) begin : g_err_n
    $error("result_packer: output word narrower than one result vector");
  end

`ifdef RESULT_PACKER_TAG_EN
  if (DATA_WIDTH_FIFO_OUT - PL < TAG_WIDTH) begin : g_err_tag
    $error("result_packer: no room for the 4-bit tag above the packed vectors");
  end
`endif

  state_e                   state_q, state_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic [PL-1:0]            pack_q, pack_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH_FIFO_OUT-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]     words_q, words_d;

  logic                     res_ready_c;
  logic                     write_c;
  logic                     hold_free;
  logic                     accept;
  logic                     complete;
  logic                     flush_load;
  logic [FW-1:0]            valid_cnt;
  logic [PL-1:0]            pack_wr;
  logic [PL-1:0]            word_payload;
  logic [DATA_WIDTH_FIFO_OUT-1:0] word_full;

  result_packer_slot_mux #(
    .L (L),
    .N (N),
    .FW(FW)
  ) u_slot_mux (
    .pack_i     (pack_q),
    .fill_i     (fill_q),
    .vec_i      (bus.res_data),
    .wr_en_i    (accept),
    .valid_cnt_i(valid_cnt),
    .pack_o     (pack_wr),
    .word_o     (word_payload)
  );

  // Handshake decode. Completing a word never collides with a stuck held word,
  // because res_ready is dropped exactly in that case.
  always_comb begin
    res_ready_c = (state_q == S_RUN) &&
                  !((fill_q == FILL_LAST) && out_valid_q && bus.outfifo_is_full);
    write_c     = out_valid_q && !bus.outfifo_is_full && enable;
    hold_free   = !out_valid_q || write_c;
    accept      = bus.res_valid && res_ready_c && enable;
    complete    = accept && (fill_q == FILL_LAST);
    flush_load  = enable && (state_q == S_FLUSH) && (fill_q != '0) && hold_free;
    valid_cnt   = complete ? FW'(N) : fill_q;
  end

  // Assemble the word for the holding register, with the optional tag on top.
  always_comb begin
    word_full = '0;
    word_full[PL-1:0] = word_payload;
`ifdef RESULT_PACKER_TAG_EN
    word_full[DATA_WIDTH_FIFO_OUT-TAG_PARITY_FROM_TOP] = ^word_payload;
    word_full[DATA_WIDTH_FIFO_OUT-TAG_CNT_FROM_TOP -: TAG_CNT_WIDTH] =
      TAG_CNT_WIDTH'(valid_cnt);
`endif
  end

  // Next-state and datapath updates. Everything holds while enable is low.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    words_d     = words_q;
    if (enable) begin
      if (write_c) begin
        out_valid_d = 1'b0;
        words_d     = words_q + CNT_WIDTH'(1);
      end
      if (accept) begin
        pack_d = pack_wr;
        fill_d = complete ? '0 : fill_q + FW'(1);
      end
      if (complete || flush_load) begin
        out_valid_d = 1'b1;
        out_data_d  = word_full;
      end
      if (flush_load) fill_d = '0;
      case (state_q)
        S_RUN:   if (flush) state_d = S_FLUSH;
        S_FLUSH: if ((fill_q == '0) || hold_free) state_d = S_DRAIN;
        S_DRAIN: if (!out_valid_q) state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= S_RUN;
    else          state_q <= state_d;
  end

  // Pack, holding and counter registers. Reset drops any pending data.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fill_q      <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      words_q     <= '0;
    end else begin
      fill_q      <= fill_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      words_q     <= words_d;
    end
  end

  assign bus.res_ready     = res_ready_c;
  assign bus.outfifo_write = write_c;
  assign bus.outfifo_din   = out_data_q;
  assign flush_done        = enable && (state_q == S_DRAIN) && !out_valid_q;
  assign words_written     = words_q;
  assign busy              = (fill_q != '0) || out_valid_q || (state_q != S_RUN);

endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Downstream neighbour of the matrix multiplication unit.
- Accepts one COLUMNS*DATA_WIDTH_MAC-bit result vector per cycle from the MXU output path and packs whole vectors LSB-first into DATA_WIDTH_FIFO_OUT-bit words.
- Drives the output data FIFO write port, with backpressure from FIFO-full and an explicit flush that emits a zero-padded partial word at end of job.
- Sits between the MXU result bus and the outfifo interface; the control unit drives flush and observes flush_done and res_ready.

Parameters:
- DATA_WIDTH_MAC, 4, bits per MAC result lane.
- COLUMNS, 3, result lanes per vector; vector width L = COLUMNS*DATA_WIDTH_MAC.
- DATA_WIDTH_FIFO_OUT, 64, output word width; vectors per word N = DATA_WIDTH_FIFO_OUT / L (floor, N >= 1, elaboration error otherwise).
- CNT_WIDTH, 16, width of the written-word counter.

Ports:
- clk  in  1  block clock.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  global enable; when low, no state changes except reset.
- res_valid  in  1  result vector valid.
- res_data  in  L  result vector.
- res_ready  out  1  packer can accept a vector this cycle.
- flush  in  1  single-cycle request to emit the pending partial word.
- flush_done  out  1  one-cycle pulse when the flush has fully drained.
- outfifo_is_full  in  1  output FIFO full, active high.
- outfifo_din  out  DATA_WIDTH_FIFO_OUT  packed word.
- outfifo_write  out  1  write strobe.
- words_written  out  CNT_WIDTH  count of words written since reset; wraps.
- busy  out  1  packer holds any data or a flush is in progress.

Behaviour:
- Storage: pack register (N slots, slot count fill 0..N) plus one output holding register (out_valid).
- Reset values: fill=0, out_valid=0, outfifo_din=0, outfifo_write=0, res_ready=1, flush_done=0, words_written=0, busy=0, state=S_RUN.
- Accept:
  - Accept occurs when res_valid && res_ready && enable.
  - res_data is written to slot index fill, occupying bits [fill*L +: L]; fill increments.
- Word completion:
  - When an accept makes fill reach N, the pack register moves to the holding register on that same edge, out_valid=1 and fill=0.
  - This move requires out_valid=0, or the held word to be written in the same cycle.
- res_ready = !(fill==N-1 && out_valid && outfifo_is_full) && state==S_RUN. For N=1: res_ready = !(out_valid && outfifo_is_full).
- Write path:
  - outfifo_write = out_valid && !outfifo_is_full && enable (combinational on registered out_valid).
  - outfifo_din holds the held word. Bits above N*L are zero.
  - On a write, out_valid clears unless it is refilled on the same edge. words_written increments.
  - Back-to-back full words give one write per cycle when the FIFO is not full. Latency is 1 clk from the accept of the Nth vector to outfifo_write.
- States:
  - S_RUN: normal operation. flush moves to S_FLUSH. A vector accepted in the same cycle as flush is included in the flushed word.
  - S_FLUSH: res_ready=0. If fill>0, the partial word moves to the holding register, with empty slots zero, once the holding register is free; fill=0. Go to S_DRAIN.
  - S_DRAIN: wait until out_valid=0, then flush_done=1 for one cycle and return to S_RUN.
  - flush with fill==0 and out_valid==0 gives flush_done 2 clk after flush with no write.
- flush asserted outside S_RUN is ignored.
- enable low freezes all registers. outfifo_write and flush_done are forced 0.
- Reset mid-operation discards pack and held data. No write occurs in the reset cycle or afterward until new data arrives.
- busy = (fill!=0) || out_valid || state!=S_RUN.

Optional Feature:
- Macro RESULT_PACKER_TAG_EN.
- With the macro:
  - The top 4 bits of each word are the tag; elaboration error if DATA_WIDTH_FIFO_OUT - N*L < 4.
  - Bits [DATA_WIDTH_FIFO_OUT-2 -: 3] hold the number of valid vectors in the word (1..N).
  - Bit DATA_WIDTH_FIFO_OUT-1 holds the even parity of bits [N*L-1:0].
- Without the macro: those bits are 0.

Decomposition:
- Shared package: derived constants L and N, state encoding S_RUN/S_FLUSH/S_DRAIN, tag field offsets.
- One natural sub-module, result_packer_slot_mux: writes a vector into slot fill of the pack register and zero-fills the tail on flush.

Test Plan (default parameters, L=12, N=5):
- 5 consecutive vectors 0x001..0x005, FIFO not full -> one write of outfifo_din=0x0000_0050_0400_3002_001 zero-extended to 64 b, 1 clk after the 5th accept; words_written=1.
- 10 back-to-back vectors with outfifo_is_full held high from the 6th -> res_ready drops after the 9th accept. Release full -> 2 writes in order, no vector lost or duplicated.
- 2 vectors 0xABC, 0x123 then flush -> one write 0x0000_0000_0123_ABC; flush_done pulses 1 clk after the write.
- flush with empty packer -> no write; flush_done exactly 2 clk after flush.
- aresetn low mid-fill (fill=3, out_valid=1) -> all outputs at reset values, no write; the next 5 vectors produce a correct fresh word.
- With RESULT_PACKER_TAG_EN: flushed single vector 0x001 -> bits[62:60]=1, bit63=1.
